// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath control FSM and the sequential ALU.
// The master drives a request; the slave (the ALU) returns status, result and flags.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [3:0]       command;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;
    logic             illegal;

    modport master (
        output start, command, operand_a, operand_b,
        input  busy, done, result, carryout, overflow, zero, illegal
    );

    modport slave (
        input  start, command, operand_a, operand_b,
        output busy, done, result, carryout, overflow, zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake: single-cycle base ops and SLTU,
// plus an iterative shift-add MULLO that holds busy for the duration of the multiply.
//
//   state | meaning
//   IDLE  | ready; base ops complete on the accept edge
//   MUL   | shift-add multiply in progress, busy high
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] CMD_ADD   = 4'b0000;
    localparam logic [3:0] CMD_SUB   = 4'b0001;
    localparam logic [3:0] CMD_XOR   = 4'b0010;
    localparam logic [3:0] CMD_SLT   = 4'b0011;
    localparam logic [3:0] CMD_AND   = 4'b0100;
    localparam logic [3:0] CMD_NAND  = 4'b0101;
    localparam logic [3:0] CMD_NOR   = 4'b0110;
    localparam logic [3:0] CMD_OR    = 4'b0111;
    localparam logic [3:0] CMD_SLTU  = 4'b1000;
    localparam logic [3:0] CMD_MULLO = 4'b1001;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic             ill_q;
    logic             done_q;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;

    logic             alu_accept;
    logic             mul_start;
    logic             mul_last;
    logic             is_mul;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] b_inv;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_co;
    logic             alu_ov;
    logic             alu_ill;
    logic [WIDTH-1:0] mul_sum;

    assign is_mul = ENABLE_MUL && (bus.command == CMD_MULLO);

    // Overflow is carry into MSB XOR carry out of MSB; carry-in is recovered from the sum bit.
    assign b_inv   = ~bus.operand_b;
    assign sum     = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    assign diff    = {1'b0, bus.operand_a} + {1'b0, b_inv} + (WIDTH+1)'(1);
    assign add_ovf = (bus.operand_a[MSB] ^ bus.operand_b[MSB] ^ sum[MSB]) ^ sum[WIDTH];
    assign sub_ovf = (bus.operand_a[MSB] ^ b_inv[MSB] ^ diff[MSB]) ^ diff[WIDTH];

    always_comb begin
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ov  = 1'b0;
        alu_ill = 1'b0;
        case (bus.command)
            CMD_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
                alu_ov  = add_ovf;
            end
            CMD_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_co  = diff[WIDTH];
                alu_ov  = sub_ovf;
            end
            CMD_XOR:  alu_res = bus.operand_a ^ bus.operand_b;
            CMD_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
                alu_ov  = sub_ovf;
            end
            CMD_AND:  alu_res = bus.operand_a & bus.operand_b;
            CMD_NAND: alu_res = ~(bus.operand_a & bus.operand_b);
            CMD_NOR:  alu_res = ~(bus.operand_a | bus.operand_b);
            CMD_OR:   alu_res = bus.operand_a | bus.operand_b;
            CMD_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
            CMD_MULLO: alu_ill = !ENABLE_MUL;
            default:  alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        alu_accept = 1'b0;
        mul_start  = 1'b0;
        mul_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end else begin
                        alu_accept = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt_q == CW'(1)) begin
                    mul_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mul_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Bit 0 is folded into the load so WIDTH bits finish in WIDTH-1 MUL cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            if (alu_accept) begin
                result_q <= alu_res;
                carry_q  <= alu_co;
                ovf_q    <= alu_ov;
                zero_q   <= (alu_res == '0);
                ill_q    <= alu_ill;
                done_q   <= 1'b1;
            end
            if (mul_start) begin
                acc_q    <= bus.operand_b[0] ? bus.operand_a : '0;
                mcand_q  <= bus.operand_a << 1;
                mplier_q <= bus.operand_b >> 1;
                cnt_q    <= CW'(WIDTH - 1);
            end
            if (state_q == MUL) begin
                acc_q    <= mul_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
                if (mul_last) begin
                    result_q <= mul_sum;
                    carry_q  <= 1'b0;
                    ovf_q    <= 1'b0;
                    zero_q   <= (mul_sum == '0);
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.busy     = (state_q == MUL);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.carryout = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.illegal  = ill_q;
endmodule
